// File: rtl/nu_pkg.sv
// Shared constants for the CPU I/O port block: register offsets and parameter defaults.
// Imported by the port slice and the top-level decoder.
package nu_pkg;

  // Register offset within a port pair (address bit 0 of the port-relative offset).
  localparam logic REG_DDR  = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int              FADE_W              = 24;
  localparam logic [FADE_W-1:0] DEFAULT_FADE_CYCLES = 24'd350000;
  localparam logic [7:0]      DEFAULT_PIN_MASK    = 8'h3F;

endpackage

// File: rtl/nu_cpu_port_if.sv
// CPU-side bus of the I/O port block: ownership, direction, address and data.
// The CPU (master) drives the request; the port block (slave) returns read data.
interface nu_cpu_port_if;
  logic        aec;
  logic        r_w;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (
    output aec, r_w, address, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  aec, r_w, address, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/nu_port_slice.sv
// One DDR/DATA port: registers, pin synchroniser, floating-bit fade latch and
// input-change flag. All state moves on the falling edge of phi2.
module nu_port_slice
  import nu_pkg::*;
#(
  parameter int                 PORT_WIDTH  = 8,
  parameter logic [PORT_WIDTH-1:0] PIN_MASK = DEFAULT_PIN_MASK[PORT_WIDTH-1:0],
  parameter logic [FADE_W-1:0]  FADE_CYCLES = DEFAULT_FADE_CYCLES
) (
  input  logic                  clock,
  input  logic                  _reset,
  input  logic                  wr_ddr,
  input  logic                  wr_data,
  input  logic                  data_rd,
  input  logic [PORT_WIDTH-1:0] wr_val,
  input  logic [PORT_WIDTH-1:0] pin,
  output logic [PORT_WIDTH-1:0] ddr,
  output logic [PORT_WIDTH-1:0] data_view,
  output logic [PORT_WIDTH-1:0] pio_out,
  output logic [PORT_WIDTH-1:0] pio_oe,
  output logic                  change
);

  logic [PORT_WIDTH-1:0] data_q;
  logic [PORT_WIDTH-1:0] fade_q;
  logic [PORT_WIDTH-1:0] sync1;
  logic [PORT_WIDTH-1:0] sync2;
  logic [FADE_W-1:0]     cnt_q;

  logic [PORT_WIDTH-1:0] ddr_n;
  logic [PORT_WIDTH-1:0] data_n;
  logic [PORT_WIDTH-1:0] fade_n;
  logic [FADE_W-1:0]     cnt_n;
  logic                  chg_set;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    ddr_n  = wr_ddr  ? wr_val : ddr;
    data_n = wr_data ? wr_val : data_q;

    if (wr_ddr || wr_data)      cnt_n = FADE_CYCLES;
    else if (cnt_q != '0)       cnt_n = cnt_q - 24'd1;
    else                        cnt_n = '0;

    // Output bits follow DATA; floating bits hold until the counter runs out.
    // A write reloads the counter, so it always beats a coincident expiry.
    fade_n = (ddr_n & data_n) |
             (~ddr_n & ((cnt_n == '0) ? '0 : fade_q));

    // sync1 != sync2 means the synchronised value changes on this edge.
    chg_set = |((sync1 ^ sync2) & PIN_MASK & ~ddr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      ddr    <= '0;
      data_q <= '0;
      fade_q <= '0;
      cnt_q  <= '0;
      sync1  <= '0;
      sync2  <= '0;
      change <= 1'b0;
    end else begin
      ddr    <= ddr_n;
      data_q <= data_n;
      fade_q <= fade_n;
      cnt_q  <= cnt_n;
      sync1  <= pin;
      sync2  <= sync1;
      change <= chg_set | (change & ~data_rd);
    end
  end

  assign pio_oe    = ddr & PIN_MASK;
  assign pio_out   = data_q & ddr & PIN_MASK;
  assign data_view = (ddr & data_q) |
                     (~ddr & ((PIN_MASK & sync2) | (~PIN_MASK & fade_q)));

endmodule

// File: rtl/nu_cpu_port.sv
// 6510-style CPU I/O port block: NUM_PORTS DDR/DATA pairs at consecutive
// addresses, with address decode, write strobes and the read multiplexer.
module nu_cpu_port
  import nu_pkg::*;
#(
  parameter int                               NUM_PORTS   = 1,
  parameter int                               PORT_WIDTH  = 8,
  parameter logic [15:0]                      BASE_ADDR   = 16'h0000,
  parameter logic [NUM_PORTS*PORT_WIDTH-1:0]  PIN_MASK    =
    {NUM_PORTS{DEFAULT_PIN_MASK[PORT_WIDTH-1:0]}},
  parameter logic [FADE_W-1:0]                FADE_CYCLES = DEFAULT_FADE_CYCLES
) (
  input  logic                            clock,
  input  logic                            _reset,
  nu_cpu_port_if.slave                    bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pio_oe,
  output logic                            irq
);

  logic [15:0]           offset;
  logic                  sel;
  logic                  wr_en;
  logic                  rd_en;
  logic [7:0]            rd_mux;
  logic [NUM_PORTS-1:0]  chg_v;
  logic [PORT_WIDTH-1:0] ddr_v  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] view_v [NUM_PORTS];

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign offset = bus.address - BASE_ADDR;
  assign sel    = bus.aec && (offset < 16'(2 * NUM_PORTS));
  assign wr_en  = sel && !bus.r_w;
  assign rd_en  = sel && bus.r_w;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic hit;
    assign hit = (offset[15:1] == 15'(k));

    nu_port_slice #(
      .PORT_WIDTH  (PORT_WIDTH),
      .PIN_MASK    (PIN_MASK[k*PORT_WIDTH +: PORT_WIDTH]),
      .FADE_CYCLES (FADE_CYCLES)
    ) u_slice (
      .clock     (clock),
      ._reset    (_reset),
      .wr_ddr    (wr_en && hit && (offset[0] == REG_DDR)),
      .wr_data   (wr_en && hit && (offset[0] == REG_DATA)),
      .data_rd   (rd_en && hit && (offset[0] == REG_DATA)),
      .wr_val    (bus.data_in[PORT_WIDTH-1:0]),
      .pin       (pio_in[k*PORT_WIDTH +: PORT_WIDTH]),
      .ddr       (ddr_v[k]),
      .data_view (view_v[k]),
      .pio_out   (pio_out[k*PORT_WIDTH +: PORT_WIDTH]),
      .pio_oe    (pio_oe[k*PORT_WIDTH +: PORT_WIDTH]),
      .change    (chg_v[k])
    );
  end

  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (offset[15:1] == 15'(k))
        rd_mux = (offset[0] == REG_DATA) ? 8'(view_v[k]) : 8'(ddr_v[k]);
    end
  end

  // Drive the CPU bus only in the phi2-high half of an owned read cycle.
  assign bus.data_oe  = clock & rd_en;
  assign bus.data_out = bus.data_oe ? rd_mux : 8'h00;
  assign irq          = |chg_v;

endmodule

// File: tb/tb_nu_cpu_port.sv
// Self-checking bench for nu_cpu_port: two ports, short fade time, scoreboard
// of expected read results popped as each read cycle returns data.
module tb_nu_cpu_port;

  localparam logic [15:0] BASE = 16'h0010;
  localparam logic [15:0] DDR0 = BASE;
  localparam logic [15:0] DAT0 = BASE + 16'd1;
  localparam logic [15:0] DDR1 = BASE + 16'd2;
  localparam logic [15:0] DAT1 = BASE + 16'd3;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       oe;
  } exp_t;

  logic        clock;
  logic        _reset;
  logic [15:0] pio_in;
  logic [15:0] pio_out;
  logic [15:0] pio_oe;
  logic        irq;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  nu_cpu_port_if bus ();

  nu_cpu_port #(
    .NUM_PORTS   (2),
    .PORT_WIDTH  (8),
    .BASE_ADDR   (BASE),
    .PIN_MASK    (16'h3F3F),
    .FADE_CYCLES (24'd10)
  ) dut (
    .clock   (clock),
    ._reset  (_reset),
    .bus     (bus),
    .pio_in  (pio_in),
    .pio_out (pio_out),
    .pio_oe  (pio_oe),
    .irq     (irq)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic exp_push(input string tag, input logic [7:0] data, input logic oe);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    e.oe   = oe;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [7:0] data, input logic oe);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 16'(sb.size()), 16'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_oe"}, 16'(oe), 16'(e.oe));
      check(e.tag, 16'(data), 16'(e.data));
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] val, input logic en = 1'b1);
    bus.aec     = en;
    bus.r_w     = 1'b0;
    bus.address = addr;
    bus.data_in = val;
    @(negedge clock);
    #1;
    bus.aec = 1'b0;
    bus.r_w = 1'b1;
  endtask

  task automatic rd(input logic [15:0] addr, input logic en = 1'b1);
    bus.aec     = en;
    bus.r_w     = 1'b1;
    bus.address = addr;
    #1;
    check("oe_low_phase", 16'(bus.data_oe), 16'd0);
    @(posedge clock);
    #1;
    observe(bus.data_out, bus.data_oe);
    @(negedge clock);
    #1;
    bus.aec = 1'b0;
  endtask

  initial begin
    _reset      = 1'b0;
    pio_in      = 16'h0000;
    bus.aec     = 1'b0;
    bus.r_w     = 1'b1;
    bus.address = 16'h0000;
    bus.data_in = 8'h00;

    #12;
    check("rst_pio_oe",  pio_oe,  16'h0000);
    check("rst_pio_out", pio_out, 16'h0000);
    check("rst_irq",     16'(irq), 16'd0);
    #5 _reset = 1'b1;
    idle(1);

    exp_push("rst_ddr0", 8'h00, 1'b1);
    rd(DDR0);

    // Outputs, mask and readback.
    wr(DDR0, 8'hFF);
    wr(DAT0, 8'h2A);
    check("out_pio_oe",  pio_oe,  16'h003F);
    check("out_pio_out", pio_out, 16'h002A);
    exp_push("out_data0", 8'h2A, 1'b1);  rd(DAT0);
    exp_push("out_ddr0",  8'hFF, 1'b1);  rd(DDR0);

    // Port 1 write leaves port 0 alone; decode boundaries and aec gating.
    wr(DAT1, 8'h55);
    exp_push("p0_ddr_kept",  8'hFF, 1'b1);  rd(DDR0);
    exp_push("p0_data_kept", 8'h2A, 1'b1);  rd(DAT0);
    exp_push("above_range",  8'h00, 1'b0);  rd(BASE + 16'd4);
    exp_push("below_range",  8'h00, 1'b0);  rd(BASE - 16'd1);
    exp_push("aec_low_read", 8'h00, 1'b0);  rd(DAT0, 1'b0);
    wr(DAT0, 8'h00, 1'b0);
    exp_push("aec_low_write", 8'h2A, 1'b1); rd(DAT0);
    wr(DDR1, 8'hFF);
    check("p1_pio_out", pio_out, 16'h152A);
    check("p1_pio_oe",  pio_oe,  16'h3F3F);
    wr(DDR1, 8'h00);
    check("irq_quiet", 16'(irq), 16'd0);

    // Input sampling through the two-flop synchroniser and change flag.
    wr(DDR0, 8'h00);
    pio_in = 16'h0015;
    idle(1);
    check("irq_one_edge", 16'(irq), 16'd0);
    idle(1);
    check("irq_set", 16'(irq), 16'd1);
    exp_push("pin_read", 8'h15, 1'b1);  rd(DAT0);
    check("irq_cleared", 16'(irq), 16'd0);

    // Change landing on the edge that completes a DATA read keeps irq.
    pio_in = 16'h002A;
    idle(2);
    check("irq_toggle", 16'(irq), 16'd1);
    pio_in = 16'h0015;
    idle(1);
    exp_push("pin_old", 8'h2A, 1'b1);  rd(DAT0);
    check("irq_set_wins", 16'(irq), 16'd1);
    exp_push("pin_new", 8'h15, 1'b1);  rd(DAT0);
    check("irq_after_read", 16'(irq), 16'd0);

    // Fade: a write on the expiry edge reloads; then a full fade to zero.
    wr(DDR0, 8'hFF);
    wr(DAT0, 8'hC0);
    wr(DDR0, 8'h3F);
    for (int i = 0; i < 9; i++) begin
      exp_push("fade_pre", 8'hC0, 1'b1);
      rd(DAT0);
    end
    wr(DDR0, 8'h3F);
    for (int i = 0; i < 12; i++) exp_push((i < 10) ? "fade_hold" : "fade_gone", (i < 10) ? 8'hC0 : 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) rd(DAT0);

    // Reset asserted in the high phase of a write aborts it.
    pio_in = 16'h0000;
    idle(2);
    bus.aec     = 1'b1;
    bus.r_w     = 1'b0;
    bus.address = DAT0;
    bus.data_in = 8'hFF;
    #5 _reset = 1'b0;
    #2;
    check("mid_rst_pio_oe",  pio_oe,  16'h0000);
    check("mid_rst_pio_out", pio_out, 16'h0000);
    check("mid_rst_irq",     16'(irq), 16'd0);
    @(negedge clock);
    #3;
    bus.aec = 1'b0;
    bus.r_w = 1'b1;
    _reset  = 1'b1;
    idle(1);
    exp_push("post_rst_ddr0",  8'h00, 1'b1);  rd(DDR0);
    exp_push("post_rst_ddr1",  8'h00, 1'b1);  rd(DDR1);
    exp_push("post_rst_data0", 8'h00, 1'b1);  rd(DAT0);
    check("post_rst_irq", 16'(irq), 16'd0);
    wr(DDR1, 8'hFF);
    check("post_rst_data1", pio_out, 16'h0000);
    check("post_rst_oe1",   pio_oe,  16'h3F00);

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
